// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WRITE} state_e;

  // An access faults on an unknown size code or when it is not naturally aligned.
  function automatic logic is_fault(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B, F3_BU: is_fault = 1'b0;
      F3_H, F3_HU: is_fault = lane[0];
      F3_W:        is_fault = (lane != 2'b00);
      default:     is_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word
// store data into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_word_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rd_word_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'b0, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'b0, shifted[15:0]};
      default: load_data_o = rd_word_i;
    endcase
  end

  // Halfword lanes are only ever 0 or 2 here; misaligned halves fault upstream.
  always_comb begin
    merge_word_o = rd_word_i;
    if (funct3_i[0]) begin
      if (lane_i[1]) merge_word_o[31:16] = wdata_i;
      else           merge_word_o[15:0]  = wdata_i;
    end else begin
      merge_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed RV32I accesses onto a word-wide data memory,
// with read-modify-write for sub-word stores and a saturating fault counter.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              dm_MemRead,
  output logic              dm_MemWrite,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_data_in,
  input  logic [31:0]       dm_data_out
);

  state_e             state_q, state_d;
  logic [31:0]        merge_q, merge_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [1:0]         lane;
  logic [ADDR_W-1:0]  word_idx;
  logic               fault;
  logic [31:0]        load_data;
  logic [31:0]        merge_word;
  logic               unused_addr_bits;

  assign lane             = addr[1:0];
  assign word_idx         = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign fault            = (state_q == IDLE) && (MemRead || MemWrite) && is_fault(funct3, lane);
  assign err_cnt          = err_q;

  lsu_lane_align u_align (
    .funct3_i     (funct3),
    .lane_i       (lane),
    .rd_word_i    (dm_data_out),
    .wdata_i      (wdata[15:0]),
    .load_data_o  (load_data),
    .merge_word_o (merge_word)
  );

  // Stores win over loads when both are requested; the WRITE cycle ignores the core.
  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rdata       = 32'b0;
    stall       = 1'b0;
    misaligned  = 1'b0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_addr     = word_idx;
    dm_data_in  = 32'b0;
    if (state_q == WRITE) begin
      dm_MemWrite = 1'b1;
      dm_addr     = addr_q;
      dm_data_in  = merge_q;
      state_d     = IDLE;
    end else if (fault) begin
      misaligned = 1'b1;
      if (err_q != '1) err_d = err_q + 1'b1;
    end else if (MemWrite) begin
      if (funct3[1]) begin
        dm_MemWrite = 1'b1;
        dm_data_in  = wdata;
      end else begin
        dm_MemRead = 1'b1;
        stall      = 1'b1;
        merge_d    = merge_word;
        addr_d     = word_idx;
        state_d    = WRITE;
      end
    end else if (MemRead) begin
      dm_MemRead = 1'b1;
      rdata      = load_data;
    end
    if (!rst_n) begin
      rdata       = 32'b0;
      stall       = 1'b0;
      misaligned  = 1'b0;
      dm_MemRead  = 1'b0;
      dm_MemWrite = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      merge_q <= 32'b0;
      addr_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised self-checking bench for load_store_unit against a word-array
// memory model and plain byte arithmetic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misaligned;
  logic [7:0]  err_cnt;
  logic        dm_MemRead, dm_MemWrite;
  logic [5:0]  dm_addr;
  logic [31:0] dm_data_in, dm_data_out;

  logic [31:0] mem    [0:63];
  logic [31:0] refMem [0:63];
  int          refErr;
  int          total = 0;
  int          bad = 0;

  logic        expValid;
  logic [31:0] expRdata, expAddr, expDin;
  logic        expStall, expMis, expRe, expWe, expAddrChk, expDinChk;
  logic [31:0] expErr;
  logic [31:0] obsRdata, obsDin;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misaligned(misaligned), .err_cnt(err_cnt),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_addr(dm_addr),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  assign dm_data_out = mem[dm_addr];
  always @(posedge clk) if (dm_MemWrite) mem[dm_addr] <= dm_data_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("rdata", rdata, expRdata);
      checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
      checkOutput("misaligned", {31'b0, misaligned}, {31'b0, expMis});
      checkOutput("dm_MemRead", {31'b0, dm_MemRead}, {31'b0, expRe});
      checkOutput("dm_MemWrite", {31'b0, dm_MemWrite}, {31'b0, expWe});
      checkOutput("err_cnt", {24'b0, err_cnt}, expErr);
      if (expAddrChk) checkOutput("dm_addr", {26'b0, dm_addr}, expAddr);
      if (expDinChk)  checkOutput("dm_data_in", dm_data_in, expDin);
    end
  end

  task automatic setExp(input logic [31:0] rd, input logic st, mis, re, we,
                        input logic ac, input logic [31:0] ad,
                        input logic dc, input logic [31:0] di);
    expRdata = rd; expStall = st; expMis = mis; expRe = re; expWe = we;
    expAddrChk = ac; expAddr = ad; expDinChk = dc; expDin = di;
    expErr = refErr;
    expValid = 1'b1;
  endtask

  task automatic endCycle();
    @(negedge clk);
    obsRdata = rdata;
    obsDin   = dm_data_in;
    @(posedge clk);
    #1;
  endtask

  // One core instruction; expected outputs come from byte arithmetic on refMem.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    int lane, idx;
    bit flt;
    logic [31:0] word, sh, val;
    logic [7:0]  b [4];
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
    lane = int'(a[1:0]);
    idx  = int'(a[7:2]);
    flt  = (rd || wr) && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
                          (f3 == 3'b010 && lane != 0) ||
                          ((f3 == 3'b001 || f3 == 3'b101) && (lane % 2) != 0));
    word = refMem[idx];
    if (flt) begin
      setExp(0, 0, 1, 0, 0, 0, 0, 0, 0);
      endCycle();
      if (refErr < 255) refErr++;
    end else if (wr) begin
      if (f3 == 3'b010) begin
        setExp(0, 0, 0, 0, 1, 1, idx, 1, wd);
        endCycle();
        refMem[idx] = wd;
      end else begin
        setExp(0, 1, 0, 1, 0, 1, idx, 0, 0);
        endCycle();
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        b[lane] = wd[7:0];
        if (f3[0]) b[lane+1] = wd[15:8];
        val = {b[3], b[2], b[1], b[0]};
        setExp(0, 0, 0, 0, 1, 1, idx, 1, val);
        endCycle();
        refMem[idx] = val;
      end
    end else if (rd) begin
      sh = word >> (8 * lane);
      case (f3)
        3'b000:  val = {{24{sh[7]}}, sh[7:0]};
        3'b100:  val = {24'b0, sh[7:0]};
        3'b001:  val = {{16{sh[15]}}, sh[15:0]};
        3'b101:  val = {16'b0, sh[15:0]};
        default: val = word;
      endcase
      setExp(val, 0, 0, 1, 0, 1, idx, 0, 0);
      endCycle();
    end else begin
      setExp(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endCycle();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int kind;
    expValid = 1'b0;
    refErr = 0;
    rst_n = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h4; wdata = 32'h5;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h1;
    mem[1] = 32'h7;
    for (int i = 0; i < 64; i++) refMem[i] = mem[i];

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_we", {31'b0, dm_MemWrite}, 32'h0);
    checkOutput("reset_re", {31'b0, dm_MemRead}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_err", {24'b0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0;

    applyStimulus(1, 0, 3'b010, 32'h4, 0);
    checkOutput("pin_lw4", obsRdata, 32'h00000007);

    // Reset asserted during the WRITE half of an SH must drop the write.
    MemRead = 0; MemWrite = 1; funct3 = 3'b001; addr = 32'h6; wdata = 32'hFFFF;
    setExp(0, 1, 0, 1, 0, 1, 1, 0, 0);
    endCycle();
    expValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstrmw_stall", {31'b0, stall}, 32'h0);
    checkOutput("rstrmw_we", {31'b0, dm_MemWrite}, 32'h0);
    checkOutput("rstrmw_err", {24'b0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    MemWrite = 0;
    refErr = 0;
    applyStimulus(1, 0, 3'b010, 32'h4, 0);
    checkOutput("pin_lw4_after_rst", obsRdata, 32'h00000007);

    applyStimulus(0, 1, 3'b010, 32'h8, 32'h80FF1234);
    applyStimulus(1, 0, 3'b000, 32'h9, 0);
    checkOutput("pin_lb9", obsRdata, 32'h00000012);
    applyStimulus(1, 0, 3'b000, 32'hB, 0);
    checkOutput("pin_lbB", obsRdata, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b101, 32'hA, 0);
    checkOutput("pin_lhuA", obsRdata, 32'h000080FF);
    applyStimulus(1, 0, 3'b001, 32'hA, 0);
    checkOutput("pin_lhA", obsRdata, 32'hFFFF80FF);

    applyStimulus(0, 1, 3'b000, 32'h5, 32'h123456AB);
    checkOutput("pin_sb5_din", obsDin, 32'h0000AB07);
    applyStimulus(1, 0, 3'b010, 32'h4, 0);
    checkOutput("pin_lw4_sb", obsRdata, 32'h0000AB07);

    applyStimulus(0, 1, 3'b000, 32'h0, 32'hEE);
    applyStimulus(0, 1, 3'b001, 32'h2, 32'hBEEF);
    applyStimulus(1, 0, 3'b010, 32'h0, 0);
    checkOutput("pin_lw0_b2b", obsRdata, 32'hBEEF00EE);

    applyStimulus(0, 1, 3'b001, 32'h1, 32'h1234);
    checkOutput("pin_err1", {24'b0, err_cnt}, 32'd1);
    applyStimulus(1, 0, 3'b011, 32'h0, 0);
    checkOutput("pin_err2", {24'b0, err_cnt}, 32'd2);
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 3'b111, $urandom, 0);
    checkOutput("pin_err_sat", {24'b0, err_cnt}, 32'd255);
    applyStimulus(1, 1, 3'b010, 32'h3, 0);
    checkOutput("pin_err_held", {24'b0, err_cnt}, 32'd255);

    rst_n = 1'b0;
    expValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    refErr = 0;

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10)      a[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      applyStimulus(kind[0], kind[1], f3, a, $urandom);
    end

    expValid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath and the 64-word data memory.
- Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses on the memory's 6-bit word port.
- Sub-word stores run as a two-cycle read-modify-write with a stall back to the core. Loads and word stores complete in a single cycle.
- Flags misaligned or illegal accesses and keeps a saturating error count.

Parameters:
- ADDR_W, 6, word-address width of the data memory (depth 2**ADDR_W words).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  core load request.
- MemWrite  in  1  core store request.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2), right-aligned.
- rdata  out  32  extended load result.
- stall  out  1  hold PC/pipeline; high only in cycle 1 of a sub-word store.
- misaligned  out  1  combinational error pulse for the current access.
- err_cnt  out  ERR_W  saturating count of faulted accesses.
- dm_MemRead  out  1  to data memory.
- dm_MemWrite  out  1  to data memory.
- dm_addr  out  ADDR_W  word address to memory.
- dm_data_in  out  32  write data to memory.
- dm_data_out  in  32  combinational read data from memory.

Behaviour:
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo memory depth. Byte lane is addr[1:0].
- Reset (async, rst_n=0):
  - state=IDLE; merge_q=0; addr_q=0; err_cnt=0.
  - stall=0, dm_MemWrite=0, dm_MemRead=0, rdata=0 while in reset.
- Fault (combinational, IDLE only):
  - Any of: funct3 in {011,110,111}; W access with addr[1:0]!=0; H/HU access with addr[0]!=0.
  - Result: misaligned=1, no dm_MemWrite, rdata=0, stall=0.
  - err_cnt increments at the clock edge and saturates at 2**ERR_W-1.
- Both MemRead and MemWrite high: treated as a store. rdata=0.
- Loads (IDLE, MemRead):
  - dm_MemRead=1, same-cycle result, 0 cycles latency.
  - Byte/half extracted by lane: B/H sign-extend; BU/HU zero-extend; W passes through.
- SW (aligned): dm_MemWrite=1 and dm_data_in=wdata in the same cycle. stall=0.
- SB/SH: FSM with states IDLE and WRITE.
  - IDLE, cycle 1:
    - dm_MemRead=1 and stall=1.
    - merge_q <= dm_data_out with wdata[7:0] (SB) or wdata[15:0] (SH) inserted at the lane; other bytes preserved.
    - addr_q <= word index; go to WRITE.
  - WRITE, cycle 2:
    - dm_MemWrite=1, dm_addr=addr_q, dm_data_in=merge_q; stall=0.
    - Core inputs are ignored, even though the request is still asserted.
    - Return to IDLE unconditionally.
  - The instruction retires at the end of WRITE. A sub-word store directly following another starts a fresh RMW and reads the just-written word.
- No request, or idle: dm_MemRead=0, dm_MemWrite=0, rdata=0, stall=0.
- Reset in WRITE: the pending write is dropped, the state returns to IDLE, and memory is unchanged.
- misaligned is never asserted in WRITE.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum {IDLE, WRITE}.
  - helper function is_fault(funct3, lane).
- Sub-module lsu_lane_align (combinational), used by the top FSM/counter wrapper:
  - Load extract plus sign/zero extension.
  - Store byte/half merge into a word.

Test Plan:
- Memory preloaded mem[0]=1, mem[1]=7. LW addr 0x4 -> rdata=0x00000007, stall=0, misaligned=0.
- Sign/zero extension, after SW addr 0x8 wdata 0x80FF1234:
  - LB 0x9 -> 0x00000012; LB 0xB -> 0xFFFFFF80.
  - LHU 0xA -> 0x000080FF; LH 0xA -> 0xFFFF80FF.
- SB addr 0x5 wdata 0x123456AB:
  - Cycle 1: stall=1, dm_MemRead=1, dm_addr=1.
  - Cycle 2: dm_MemWrite=1, dm_data_in=0x0000AB07, stall=0.
  - Then LW 0x4 -> 0x0000AB07.
- Back-to-back SB 0x0 wdata 0xEE then SH 0x2 wdata 0xBEEF -> LW 0x0 = 0xBEEF00EE. Four total cycles, stall pattern 1,0,1,0.
- Faults:
  - SH addr 0x1 -> misaligned=1, no write, err_cnt=1.
  - funct3=011 -> err_cnt=2.
  - 300 faulting accesses -> err_cnt=255, held.
- Reset mid-RMW: SH addr 0x6 wdata 0xFFFF, rst_n=0 during the WRITE cycle -> no dm_MemWrite edge, LW 0x4 still 0x00000007, stall=0, err_cnt=0.
